// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath: opcodes, ALU operations,
// sequencer states and instruction field positions.
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int INSTR_W  = 16;

  localparam int OPC_LSB  = 12;
  localparam int WA_LSB   = 8;
  localparam int RA1_LSB  = 4;
  localparam int RA2_LSB  = 0;
  localparam int IMM_LSB  = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BZ   = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  function automatic logic [REG_AW-1:0] reg_field(input logic [INSTR_W-1:0] ir, input int lsb);
    return ir[lsb +: REG_AW];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between instr_sequencer and its ROM, register file and ALU.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  import cpu_pkg::*;

  logic                 start;
  logic [INSTR_W-1:0]   instr;
  logic                 alu_zero;
  logic [PC_W-1:0]      pc;
  logic [REG_AW-1:0]    RA1;
  logic [REG_AW-1:0]    RA2;
  logic [REG_AW-1:0]    WA;
  logic [DATA_W-1:0]    imm;
  logic                 imm_sel;
  alu_op_t              alu_op;
  logic                 write_enable;
  logic                 busy;
  logic                 halted;
  logic                 illegal;

  modport master (
    input  start, instr, alu_zero,
    output pc, RA1, RA2, WA, imm, imm_sel, alu_op, write_enable, busy, halted, illegal
  );

  modport slave (
    output start, instr, alu_zero,
    input  pc, RA1, RA2, WA, imm, imm_sel, alu_op, write_enable, busy, halted, illegal
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits an instruction word into register
// addresses, immediate and ALU control, and classifies the opcode.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output logic [REG_AW-1:0]  o_ra1,
  output logic [REG_AW-1:0]  o_ra2,
  output logic [REG_AW-1:0]  o_wa,
  output logic [DATA_W-1:0]  o_imm,
  output alu_op_t            o_alu_op,
  output logic               o_imm_sel,
  output logic               o_is_write,
  output logic               o_is_branch,
  output logic               o_is_illegal
);

  logic [3:0] w_opc;

  assign w_opc = i_ir[OPC_LSB +: 4];
  assign o_ra1 = reg_field(i_ir, RA1_LSB);
  assign o_ra2 = reg_field(i_ir, RA2_LSB);
  assign o_wa  = reg_field(i_ir, WA_LSB);
  assign o_imm = i_ir[IMM_LSB +: DATA_W];

  always_comb begin
    o_alu_op     = ALU_ADD;
    o_imm_sel    = 1'b0;
    o_is_write   = 1'b0;
    o_is_branch  = 1'b0;
    o_is_illegal = 1'b0;
    case (w_opc)
      OP_NOP, OP_HALT: begin
        o_is_write = 1'b0;
      end
      OP_ADD: begin o_alu_op = ALU_ADD; o_is_write = 1'b1; end
      OP_SUB: begin o_alu_op = ALU_SUB; o_is_write = 1'b1; end
      OP_AND: begin o_alu_op = ALU_AND; o_is_write = 1'b1; end
      OP_OR:  begin o_alu_op = ALU_OR;  o_is_write = 1'b1; end
      OP_XOR: begin o_alu_op = ALU_XOR; o_is_write = 1'b1; end
      OP_LDI: begin o_imm_sel = 1'b1;   o_is_write = 1'b1; end
      OP_MOV: begin o_alu_op = ALU_PASS_A; o_is_write = 1'b1; end
      OP_JMP, OP_BZ: begin
        o_is_branch = 1'b1;
      end
      default: begin
        o_is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer driving the register
// file and ALU; owns the FSM, program counter, instruction register and Z flag.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  instr_sequencer_if.master bus
);

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic                r_z, w_z_nxt;
  logic                r_rst_done;
  logic                w_start_ok;
  logic                w_dec_stage;
  logic [3:0]          w_opc;

  logic [REG_AW-1:0]   w_ra1, w_ra2, w_wa;
  logic [DATA_W-1:0]   w_imm;
  alu_op_t             w_alu_op;
  logic                w_imm_sel, w_is_write, w_is_branch, w_is_illegal;

  logic [REG_AW-1:0]   r_ra1, r_ra2, r_wa;
  logic [DATA_W-1:0]   r_imm;
  alu_op_t             r_alu_op;
  logic                r_imm_sel, r_we, r_busy, r_halted, r_illegal;

  // Decoding the next IR lets every control output be a plain register.
  instr_decode u_decode (
    .i_ir         (w_ir_nxt),
    .o_ra1        (w_ra1),
    .o_ra2        (w_ra2),
    .o_wa         (w_wa),
    .o_imm        (w_imm),
    .o_alu_op     (w_alu_op),
    .o_imm_sel    (w_imm_sel),
    .o_is_write   (w_is_write),
    .o_is_branch  (w_is_branch),
    .o_is_illegal (w_is_illegal)
  );

  assign w_opc       = r_ir[OPC_LSB +: 4];
  assign w_start_ok  = bus.start & r_rst_done;
  assign w_dec_stage = (w_state_nxt == ST_DECODE) || (w_state_nxt == ST_EXEC) ||
                       (w_state_nxt == ST_WB);

  always_comb begin
    w_ir_nxt = r_ir;
    if (r_state == ST_FETCH) begin
      w_ir_nxt = bus.instr;
    end else begin
      w_ir_nxt = r_ir;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_z_nxt     = r_z;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_FETCH;
        else            w_state_nxt = ST_IDLE;
      end
      ST_FETCH:  w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_opc == OP_HALT) w_state_nxt = ST_HALTED;
        else                  w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_state_nxt = ST_FETCH;
        case (w_opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: w_z_nxt = bus.alu_zero;
          OP_LDI:  w_z_nxt = (w_imm == {DATA_W{1'b0}});
          default: w_z_nxt = r_z;
        endcase
        // BZ tests the flag left by the previous instruction.
        if (w_is_branch && ((w_opc == OP_JMP) || r_z)) begin
          w_pc_nxt = PC_W'(w_imm);
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      ST_HALTED: begin
        if (w_start_ok) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = {PC_W{1'b0}};
          w_z_nxt     = 1'b0;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Start is not honoured on the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rst_done <= 1'b0;
    else        r_rst_done <= 1'b1;
  end

  // FSM state, program counter, instruction register and Z flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_pc    <= {PC_W{1'b0}};
      r_ir    <= {INSTR_W{1'b0}};
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_z     <= w_z_nxt;
    end
  end

  // Registered control outputs, valid from DECODE through WB and zero elsewhere.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ra1     <= {REG_AW{1'b0}};
      r_ra2     <= {REG_AW{1'b0}};
      r_wa      <= {REG_AW{1'b0}};
      r_imm     <= {DATA_W{1'b0}};
      r_alu_op  <= ALU_ADD;
      r_imm_sel <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_ra1     <= w_dec_stage ? w_ra1 : {REG_AW{1'b0}};
      r_ra2     <= w_dec_stage ? w_ra2 : {REG_AW{1'b0}};
      r_wa      <= w_dec_stage ? w_wa  : {REG_AW{1'b0}};
      r_imm     <= w_dec_stage ? w_imm : {DATA_W{1'b0}};
      r_alu_op  <= w_dec_stage ? w_alu_op : ALU_ADD;
      r_imm_sel <= w_dec_stage & w_imm_sel;
      r_we      <= (w_state_nxt == ST_WB) & w_is_write;
      r_busy    <= (w_state_nxt == ST_FETCH) | w_dec_stage;
      r_halted  <= (w_state_nxt == ST_HALTED);
      r_illegal <= (w_state_nxt == ST_EXEC) & w_is_illegal;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.RA1          = r_ra1;
  assign bus.RA2          = r_ra2;
  assign bus.WA           = r_wa;
  assign bus.imm          = r_imm;
  assign bus.imm_sel      = r_imm_sel;
  assign bus.alu_op       = r_alu_op;
  assign bus.write_enable = r_we;
  assign bus.busy         = r_busy;
  assign bus.halted       = r_halted;
  assign bus.illegal      = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a ROM, register-file and ALU model.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic CLK;
  logic RST_N;
  instr_sequencer_if #(.PC_W(8)) u_if ();

  instr_sequencer #(.PC_W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if.master)
  );

  logic [15:0] rom  [256];
  logic [7:0]  regs [16];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  int          ill_cnt  = 0;
  int          cyc      = 0;
  logic [3:0]  log_wa  [64];
  logic [3:0]  log_ra1 [64];
  logic [3:0]  log_ra2 [64];
  logic [2:0]  log_op  [64];
  int          log_cyc [64];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      default: return 8'd0;
    endcase
  endfunction

  assign u_if.instr    = rom[u_if.pc];
  assign u_if.alu_zero = (alu_fn(regs[u_if.RA1], regs[u_if.RA2], u_if.alu_op) == 8'd0);

  // Register-file model plus write/illegal monitors.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else if (u_if.write_enable) begin
      regs[u_if.WA] <= u_if.imm_sel ? u_if.imm : alu_fn(regs[u_if.RA1], regs[u_if.RA2], u_if.alu_op);
      log_wa[wr_cnt[5:0]]  <= u_if.WA;
      log_ra1[wr_cnt[5:0]] <= u_if.RA1;
      log_ra2[wr_cnt[5:0]] <= u_if.RA2;
      log_op[wr_cnt[5:0]]  <= u_if.alu_op;
      log_cyc[wr_cnt[5:0]] <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (RST_N && u_if.illegal) ill_cnt <= ill_cnt + 1;
  end

  function automatic logic [63:0] outs_vec();
    return {28'd0, u_if.pc, u_if.RA1, u_if.RA2, u_if.WA, u_if.imm, u_if.imm_sel,
            u_if.alu_op, u_if.write_enable, u_if.busy, u_if.halted, u_if.illegal};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    u_if.start = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1;
    @(negedge CLK);
    u_if.start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!u_if.halted && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_val(tag, {63'd0, u_if.halted}, 64'd1);
  endtask

  initial begin
    int w0;
    int i0;
    RST_N = 1'b0;
    u_if.start = 1'b0;
    clear_rom();

    // Reset and start
    @(negedge CLK);
    check_val("rst_outs", outs_vec(), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_val("idle_outs", outs_vec(), 64'd0);
    pulse_start();
    check_val("start_busy", {63'd0, u_if.busy}, 64'd1);
    check_val("fetch_pc", {56'd0, u_if.pc}, 64'd0);

    // LDI R1,3; LDI R2,5; ADD R10,R1,R2; HALT
    clear_rom();
    rom[0] = 16'h6103; rom[1] = 16'h6205; rom[2] = 16'h1A12; rom[3] = 16'hF000;
    do_reset();
    w0 = wr_cnt;
    pulse_start();
    wait_halt("ldi_add_halt", 40);
    check_val("ldi_add_nwr", 64'(wr_cnt - w0), 64'd3);
    check_val("wr0_wa", {60'd0, log_wa[w0]}, 64'd1);
    check_val("wr1_wa", {60'd0, log_wa[w0+1]}, 64'd2);
    check_val("wr2_wa", {60'd0, log_wa[w0+2]}, 64'd10);
    check_val("wr2_op", {61'd0, log_op[w0+2]}, 64'd0);
    check_val("wr2_ra1", {60'd0, log_ra1[w0+2]}, 64'd1);
    check_val("wr2_ra2", {60'd0, log_ra2[w0+2]}, 64'd2);
    check_val("wr_gap01", 64'(log_cyc[w0+1] - log_cyc[w0]), 64'd4);
    check_val("wr_gap12", 64'(log_cyc[w0+2] - log_cyc[w0+1]), 64'd4);
    check_val("r10_data", {56'd0, regs[10]}, 64'd8);
    check_val("halt_busy", {63'd0, u_if.busy}, 64'd0);
    check_val("halt_pc", {56'd0, u_if.pc}, 64'd3);

    // Branch taken: LDI R3,0; BZ 0x20
    clear_rom();
    rom[0] = 16'h6300; rom[1] = 16'h9020; rom[2] = 16'hF000; rom[8'h20] = 16'hF000;
    do_reset();
    pulse_start();
    wait_halt("bz_taken_halt", 40);
    check_val("bz_taken_pc", {56'd0, u_if.pc}, 64'h20);

    // Branch not taken: LDI R3,7; BZ 0x20
    rom[0] = 16'h6307;
    do_reset();
    pulse_start();
    wait_halt("bz_not_halt", 40);
    check_val("bz_not_pc", {56'd0, u_if.pc}, 64'h02);

    // Wrap-around: JMP 0xFF, NOP at 0xFF
    clear_rom();
    rom[0] = 16'h80FF;
    do_reset();
    pulse_start();
    repeat (3) @(negedge CLK);
    check_val("jmp_wb_pc", {56'd0, u_if.pc}, 64'h00);
    @(negedge CLK);
    check_val("jmp_fetch_pc", {56'd0, u_if.pc}, 64'hFF);
    repeat (4) @(negedge CLK);
    check_val("wrap_pc", {56'd0, u_if.pc}, 64'h00);

    // Illegal opcode 0xB followed by HALT, then resume
    clear_rom();
    rom[0] = 16'hB123; rom[1] = 16'hF000;
    do_reset();
    w0 = wr_cnt;
    i0 = ill_cnt;
    pulse_start();
    @(negedge CLK);
    @(negedge CLK);
    check_val("ill_exec", {63'd0, u_if.illegal}, 64'd1);
    @(negedge CLK);
    check_val("ill_wb_clear", {63'd0, u_if.illegal}, 64'd0);
    repeat (3) @(negedge CLK);
    check_val("halt_not_yet", {62'd0, u_if.halted, u_if.busy}, 64'd1);
    @(negedge CLK);
    check_val("halt_state", {62'd0, u_if.halted, u_if.busy}, 64'd2);
    check_val("ill_pulses", 64'(ill_cnt - i0), 64'd1);
    check_val("ill_no_write", 64'(wr_cnt - w0), 64'd0);
    pulse_start();
    check_val("resume_pc", {56'd0, u_if.pc}, 64'd0);
    check_val("resume_state", {62'd0, u_if.halted, u_if.busy}, 64'd1);

    // Reset during WB of ADD
    clear_rom();
    rom[0] = 16'h6103; rom[1] = 16'h6205; rom[2] = 16'h1A12;
    do_reset();
    w0 = wr_cnt;
    pulse_start();
    repeat (11) @(negedge CLK);
    check_val("add_wb_we", {59'd0, u_if.write_enable, u_if.WA}, 64'h1A);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("we_async_drop", {63'd0, u_if.write_enable}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("post_rst_outs", outs_vec(), 64'd0);
    check_val("mid_rst_nwr", 64'(wr_cnt - w0), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control unit for the 8-bit datapath. Fetches 16-bit instructions from an asynchronous instruction ROM, decodes them, and drives the register-file read/write addresses, ALU operation, immediate path and write enable. It sits directly upstream of `reg_file`: its `RA1/RA2/WA/write_enable` outputs connect straight to the register file. It closes the loop through the ALU zero flag for conditional branches.

## Interface
- `PC_W`, 8: program-counter width; ROM depth is 2^PC_W.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `start` in 1: level-sampled start request, honoured in IDLE and HALTED.
- `instr` in 16: ROM data for address `pc`, valid combinationally in the same cycle.
- `alu_zero` in 1: ALU result == 0, combinational from current RD1/RD2/alu_op.
- `pc` out PC_W: instruction address.
- `RA1`, `RA2`, `WA` out 4 each: register-file read and write addresses.
- `imm` out 8: immediate field of the current instruction.
- `imm_sel` out 1: 1 selects `imm` onto the register-file write data instead of the ALU result.
- `alu_op` out 3: ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASS_A=5.
- `write_enable` out 1: register-file write strobe.
- `busy` out 1: high in FETCH/DECODE/EXEC/WB.
- `halted` out 1: high in HALTED.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Instruction format: `[15:12]` opcode, `[11:8]` WA, `[7:4]` RA1, `[3:0]` RA2; imm = `[7:0]`.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: WA <= RA1 op RA2.
  - 6 LDI: WA <= imm.
  - 7 MOV: WA <= RA1, using PASS_A.
  - 8 JMP: pc <= imm.
  - 9 BZ: pc <= imm if the Z flag is set.
  - F HALT.
  - A–E: illegal; executed as NOP with an `illegal` pulse in EXEC.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE -> FETCH when `start` is high.
  - FETCH: IR <= instr.
  - FETCH -> DECODE -> EXEC -> WB -> FETCH.
  - EXEC -> HALTED on HALT; the WB state is skipped.
  - HALTED -> FETCH when `start` is high, with pc <= 0 and Z <= 0.
- Output drive:
  - `RA1/RA2/WA/imm/alu_op/imm_sel` are decoded from IR and held stable from DECODE through WB.
  - `write_enable` is high only in WB, and only for opcodes 1–7.
- Z flag: registered; updated in WB from `alu_zero` for opcodes 1–5 and 7. LDI sets Z = (imm == 0). All other opcodes leave Z unchanged.
- PC update, at the WB -> FETCH transition:
  - pc <= imm for JMP, or for BZ when Z is set.
  - Otherwise pc <= pc + 1, modulo 2^PC_W (wraps 255 -> 0).
- Reset (asynchronous, any state, mid-instruction included):
  - state = IDLE, pc = 0, IR = 0, Z = 0.
  - All outputs 0; any in-flight write is dropped.

## Timing
- Every instruction takes 4 cycles from FETCH entry to the next FETCH. HALT takes 3 cycles to reach HALTED.
- `write_enable` is a single-cycle pulse. The register file captures the write at the rising edge that ends WB.
- Back-to-back dependency (write Rn, then read Rn) needs no forwarding. The write commits before the next DECODE.
- `alu_zero` is sampled at the WB-ending edge, and applies to the instruction in WB.
- `start` held high while `busy` has no effect. Start is ignored when `RST_N` deasserts in the same cycle.
- `pc` changes only at the WB -> FETCH edge or on the HALTED -> FETCH edge. It is stable during FETCH for the ROM.

## Structure
- Shared package `cpu_pkg`:
  - opcode enum `opcode_t`.
  - `alu_op_t` enum.
  - FSM `state_t` enum.
  - field-position localparams.
  - `NUM_REGS = 16` and `DATA_W = 8`; `reg_file` and the ALU also import these.
- Sub-module `instr_decode`: combinational IR -> {RA1, RA2, WA, imm, alu_op, imm_sel, is_write, is_branch, is_illegal}.
- The FSM, PC, IR and Z flag stay in `instr_sequencer`.

## Test plan
- Reset/start: hold RST_N = 0 for 2 cycles, then release and pulse start.
  - Required: all outputs stay 0 until start.
  - pc = 0 in the first FETCH; busy = 1 from the cycle after start.
- LDI/ADD: program LDI R1,3; LDI R2,5; ADD R10,R1,R2.
  - Required: write_enable pulses with WA = 1, 2, then 10, with alu_op = ADD, RA1 = 1 and RA2 = 2 on the third.
  - Exactly 4 cycles between pulses.
- Branch taken/not taken:
  - LDI R3,0; BZ 0x20 -> pc = 0x20.
  - LDI R3,7; BZ 0x20 -> pc = next sequential address.
- Wrap-around: JMP 0xFF with a NOP at 0xFF -> pc goes 0xFF then 0x00.
- Illegal/HALT:
  - Opcode 0xB -> `illegal` pulses for 1 cycle and write_enable stays 0.
  - HALT -> halted = 1 and busy = 0; start then resumes at pc = 0.
- Mid-instruction reset: drop RST_N during WB of an ADD.
  - Required: write_enable falls immediately (asynchronously) and no write occurs.
  - After release: state IDLE, pc = 0.
